// File: rtl/imm_pkg.sv
// Shared constants for the immediate-generation pipeline: RV32 major opcodes
// and the output format encoding.
package imm_pkg;

  localparam int FMT_W = 3;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction-to-immediate decoder: extracts the RV32 immediate
// field, sign-extends it from instr[31] to XLEN, and flags unknown opcodes.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic signed [31:0]     imm32;
  logic signed [XLEN-1:0] imm_ext;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OP_IMM, OP_LOAD, OP_JALR: begin
          fmt   = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
        OP_STORE: begin
          fmt   = FMT_S;
          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end
        OP_BRANCH: begin
          fmt   = FMT_B;
          imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        OP_LUI, OP_AUIPC: begin
          fmt   = FMT_U;
          imm32 = {instr[31:12], 12'b0};
        end
        OP_JAL: begin
          fmt   = FMT_J;
          imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        OP_OP: begin
          fmt = FMT_NONE;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

  // Signed cast widens from bit 31, so U-type is sign-extended on RV64 too.
  assign imm_ext = XLEN'(imm32);
  assign imm     = imm_ext;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry skid buffer on the result path and a
// saturating illegal-instruction counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [FMT_W-1:0] out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] err_cnt
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } res_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: combinational decode of the incoming instruction
  logic [XLEN-1:0] dec_imm_p0;
  fmt_e            dec_fmt_p0;
  logic            dec_ill_p0;
  res_t            new_p0;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm_p0),
    .fmt     (dec_fmt_p0),
    .illegal (dec_ill_p0)
  );

  assign new_p0 = '{imm: dec_imm_p0, fmt: dec_fmt_p0, tag: in_tag, illegal: dec_ill_p0};

  // Stage p1: main entry drives the outputs, skid entry absorbs one extra result
  res_t             main_p1, skid_p1, main_n, skid_n;
  logic             mvld_p1, svld_p1, mvld_n, svld_n;
  logic [CNT_W-1:0] cnt_p1;
  logic             acc, deq;

  assign acc = in_valid && in_ready;
  assign deq = mvld_p1 && out_ready;

  always_comb begin
    mvld_n = mvld_p1;
    svld_n = svld_p1;
    main_n = main_p1;
    skid_n = skid_p1;
    if (deq) begin
      if (svld_p1) begin
        // in_ready is low whenever the skid is full, so no accept here
        main_n = skid_p1;
        svld_n = 1'b0;
      end else begin
        mvld_n = acc;
        if (acc) main_n = new_p0;
      end
    end else if (acc) begin
      if (mvld_p1) begin
        svld_n = 1'b1;
        skid_n = new_p0;
      end else begin
        mvld_n = 1'b1;
        main_n = new_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mvld_p1 <= 1'b0;
      svld_p1 <= 1'b0;
      main_p1 <= '0;
      skid_p1 <= '0;
      cnt_p1  <= '0;
    end else begin
      mvld_p1 <= mvld_n;
      svld_p1 <= svld_n;
      main_p1 <= main_n;
      skid_p1 <= skid_n;
      if (acc && dec_ill_p0) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign in_ready    = !svld_p1;
  assign out_valid   = mvld_p1;
  assign out_imm     = main_p1.imm;
  assign out_fmt     = main_p1.fmt;
  assign out_tag     = main_p1.tag;
  assign out_illegal = main_p1.illegal;
  assign err_cnt     = cnt_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a default RV32 instance and an RV64 /
// 2-bit-counter instance share the same stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [4:0]  a_out_tag;
  logic [7:0]  a_err_cnt;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [4:0]  b_out_tag;
  logic [1:0]  b_err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_tag(a_out_tag), .out_illegal(a_out_illegal), .err_cnt(a_err_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_tag(b_out_tag), .out_illegal(b_out_illegal), .err_cnt(b_err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [4:0] tag);
    in_valid = 1'b1;
    in_instr = instr;
    in_tag   = tag;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid",   a_out_valid, 0);
    chk("rst_illegal", a_out_illegal, 0);
    chk("rst_imm",     a_out_imm, 0);
    chk("rst_fmt",     a_out_fmt, 0);
    chk("rst_tag",     a_out_tag, 0);
    chk("rst_err",     a_err_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_valid_b",  b_out_valid, 0);

    // Decode of each format with the output always ready
    out_ready = 1'b1;
    send(32'hFFF00093, 5'd7);
    chk("i_valid",   a_out_valid, 1);
    chk("i_imm",     a_out_imm, 32'hFFFFFFFF);
    chk("i_fmt",     a_out_fmt, 1);
    chk("i_illegal", a_out_illegal, 0);
    chk("i_tag",     a_out_tag, 7);
    chk("i_imm64",   b_out_imm, 64'hFFFFFFFFFFFFFFFF);
    send(32'hFE000EE3, 5'd8);
    chk("b_imm", a_out_imm, 32'hFFFFFFFC);
    chk("b_fmt", a_out_fmt, 3);
    send(32'h800000B7, 5'd9);
    chk("u_imm",   a_out_imm, 32'h80000000);
    chk("u_imm64", b_out_imm, 64'hFFFFFFFF80000000);
    chk("u_fmt",   b_out_fmt, 4);
    send(32'h00112623, 5'd10);
    chk("s_imm", a_out_imm, 32'd12);
    chk("s_fmt", a_out_fmt, 2);
    send(32'h0080006F, 5'd11);
    chk("j_imm", a_out_imm, 32'd8);
    chk("j_fmt", a_out_fmt, 5);
    send(32'h002081B3, 5'd12);
    chk("r_imm",     a_out_imm, 0);
    chk("r_fmt",     a_out_fmt, 0);
    chk("r_illegal", a_out_illegal, 0);
    chk("r_err",     a_err_cnt, 0);
    in_valid = 1'b0;
    tick();
    chk("idle_valid", a_out_valid, 0);

    // Five illegal opcodes: 8-bit counter climbs, 2-bit counter saturates at 3
    for (int k = 1; k <= 5; k++) begin
      send(32'h0000007F, 5'(k));
      chk("ill_flag",  a_out_illegal, 1);
      chk("ill_imm",   a_out_imm, 0);
      chk("ill_fmt",   a_out_fmt, 0);
      chk("ill_err_a", a_err_cnt, 64'(k));
      chk("ill_err_b", b_err_cnt, (k > 3) ? 64'd3 : 64'(k));
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: two accepted, then stall, then drain in order
    out_ready = 1'b0;
    chk("bp_ready0", a_in_ready, 1);
    send(32'h00100093, 5'd1);
    chk("bp_ready1", a_in_ready, 1);
    chk("bp_tag1",   a_out_tag, 1);
    send(32'h00100093, 5'd2);
    chk("bp_ready2", a_in_ready, 0);
    send(32'h00300093, 5'd3);
    chk("bp_hold_tag", a_out_tag, 1);
    chk("bp_hold_imm", a_out_imm, 1);
    tick();
    chk("bp_hold_tag2", a_out_tag, 1);
    chk("bp_hold_vld",  a_out_valid, 1);
    chk("bp_ready3",    a_in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_out2",    a_out_tag, 2);
    chk("bp_ready_up", a_in_ready, 1);
    tick();
    chk("bp_out3",     a_out_tag, 3);
    chk("bp_out3_imm", a_out_imm, 3);
    send(32'h00400093, 5'd4);
    chk("bp_out4", a_out_tag, 4);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", a_out_valid, 0);

    // Mid-operation reset with both entries full and err_cnt at 5
    out_ready = 1'b0;
    send(32'h00100093, 5'd9);
    send(32'h00100093, 5'd10);
    chk("mr_full",  a_in_ready, 0);
    chk("mr_err5",  a_err_cnt, 5);
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h0000007F;
    tick();
    chk("mr_valid", a_out_valid, 0);
    chk("mr_err",   a_err_cnt, 0);
    chk("mr_ready", a_in_ready, 1);
    chk("mr_err_b", b_err_cnt, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_no_stale", a_out_valid, 0);
    end

    // Full throughput: 16 back-to-back instructions
    for (int k = 0; k < 16; k++) begin
      chk("tp_ready", a_in_ready, 1);
      send((32'(k) << 20) | 32'h13, 5'(k));
      chk("tp_valid", a_out_valid, 1);
      chk("tp_tag",   a_out_tag, 64'(k));
      chk("tp_imm",   a_out_imm, 64'(k));
    end
    in_valid = 1'b0;
    tick();
    chk("tp_end", a_out_valid, 0);

    // Low two bits not 11 is illegal regardless of the rest
    send(32'h00000010, 5'd3);
    chk("lb_illegal", a_out_illegal, 1);
    chk("lb_fmt",     a_out_fmt, 0);
    chk("lb_imm",     a_out_imm, 0);
    chk("lb_err",     a_err_cnt, 1);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
